// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
// Parity modes, FSM state encoding and a parameter legality check.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic bit params_ok(
    input int cpb,
    input int db,
    input int par,
    input int sb,
    input int depth
  );
    return (cpb >= 2)
        && (db >= 5) && (db <= 9)
        && (par >= PARITY_NONE) && (par <= PARITY_EVEN)
        && ((sb == 1) || (sb == 2))
        && (depth >= 2)
        && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; pushes when full and pops when
// empty are ignored. Ports: push/pop strobes, data in/out, full/empty/count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with input FIFO, parity and 1/2 stop bits, LSB first.
// Ports: clock/reset, has_data/data_to_send/ready push side, serial line
// sending_bit, is_transmitting, transmission_done pulse, fifo_count.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 87,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          has_data,
  input  logic [DATA_BITS-1:0]          data_to_send,
  output logic                          ready,
  output logic                          sending_bit,
  output logic                          is_transmitting,
  output logic                          transmission_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  if (!params_ok(CLOCKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH))
  begin : g_bad_params
    $error("uart_tx_framed: illegal parameter set");
  end

  state_t               state;
  state_t               nxt;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 done_q;
  logic                 pop;
  logic                 line_nx;
  logic                 end_stop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] head;
  logic                 tick;
  logic                 data_last;
  logic                 stop_last;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (has_data),
    .pop      (pop),
    .data_in  (data_to_send),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign ready     = !full;
  assign tick      = (bit_cnt == CW'(CLOCKS_PER_BIT - 1));
  assign data_last = (bit_idx == IW'(DATA_BITS - 1));
  assign stop_last = (bit_idx == IW'(STOP_BITS - 1));

  always_comb begin
    nxt      = state;
    pop      = 1'b0;
    line_nx  = 1'b1;
    end_stop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = ST_START;
        end
      end
      ST_START: begin
        line_nx = 1'b0;
        if (tick) nxt = ST_DATA;
      end
      ST_DATA: begin
        line_nx = shreg[0];
        if (tick && data_last)
          nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_nx = par_bit;
        if (tick) nxt = ST_STOP;
      end
      ST_STOP: begin
        if (tick && stop_last) begin
          end_stop = 1'b1;
          // Chain straight into the next start bit when data is queued.
          if (!empty) begin
            pop = 1'b1;
            nxt = ST_START;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Line and status are registered one cycle behind the state, so the
  // line falls two edges after the push that woke an idle transmitter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      sending_bit       <= 1'b1;
      is_transmitting   <= 1'b0;
      done_q            <= 1'b0;
      transmission_done <= 1'b0;
    end else begin
      state             <= nxt;
      sending_bit       <= line_nx;
      is_transmitting   <= (state != ST_IDLE);
      done_q            <= end_stop;
      transmission_done <= done_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= head;
      par_bit <= (^head) ^ (PARITY == PARITY_ODD);
    end else if (state == ST_IDLE) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      bit_cnt <= tick ? '0 : bit_cnt + 1'b1;
      if (tick && state == ST_DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= data_last ? '0 : bit_idx + 1'b1;
      end
      if (tick && state == ST_STOP)
        bit_idx <= stop_last ? '0 : bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: two configurations, scoreboard of expected
// frames, negedge line monitor comparing every cycle of every frame.
module tb_uart_tx_framed;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int fails = 0;
  bit ch_done [2];

  task automatic chk(input string name, input int ch,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL ch%0d %s: got %0h expected %0h", ch, name, act, exp);
    end
  endtask

  // Line level of every bit of a frame, bit 0 = start bit.
  function automatic logic [15:0] frame_bits(input int db, input int par,
                                             input int sb,
                                             input logic [8:0] d);
    logic [15:0] f;
    int n;
    int ones;
    f = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par == 1) begin
      f[n] = ((ones % 2) == 0);
      n++;
    end else if (par == 2) begin
      f[n] = ((ones % 2) == 1);
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int DB  = (g == 0) ? 8 : 7;
    localparam int PAR = (g == 0) ? 2 : 1;
    localparam int SB  = (g == 0) ? 1 : 2;
    localparam int LEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FL  = LEN * CPB;
    localparam logic [8:0] FIRST  = (g == 0) ? 9'h0A5 : 9'h001;
    localparam logic [8:0] SECOND = (g == 0) ? 9'h0FF : 9'h000;

    logic          reset    = 1'b1;
    logic          has_data = 1'b0;
    logic [DB-1:0] data     = '0;
    logic          ready;
    logic          line;
    logic          busy;
    logic          done;
    logic [2:0]    count;

    uart_tx_framed #(
      .CLOCKS_PER_BIT (CPB),
      .DATA_BITS      (DB),
      .PARITY         (PAR),
      .STOP_BITS      (SB),
      .FIFO_DEPTH     (DEPTH)
    ) dut (
      .clock             (clock),
      .reset             (reset),
      .has_data          (has_data),
      .data_to_send      (data),
      .ready             (ready),
      .sending_bit       (line),
      .is_transmitting   (busy),
      .transmission_done (done),
      .fifo_count        (count)
    );

    logic [15:0] expq [$];
    int          idle_errs = 0;
    int          b2b       = 0;
    bit          active    = 1'b0;
    int          cyc       = 0;
    int          bad       = 0;
    logic [15:0] cur;
    logic [15:0] got;

    task automatic tick();
      @(posedge clock);
      #1;
    endtask

    task automatic push(input logic [8:0] d);
      logic [8:0] dm;
      dm = '0;
      dm[DB-1:0] = d[DB-1:0];
      has_data = 1'b1;
      data = d[DB-1:0];
      if (ready) expq.push_back(frame_bits(DB, PAR, SB, dm));
      tick();
      has_data = 1'b0;
      data = DB'($urandom);
    endtask

    task automatic wait_idle();
      for (int i = 0; i < 4000; i++) begin
        if (!busy && count == 0 && expq.size() == 0 && !active) return;
        tick();
      end
      total++;
      fails++;
      $display("FAIL ch%0d idle_wait: still busy after 4000 cycles", g);
    endtask

    task automatic start_frame(input bit is_b2b);
      if (expq.size() == 0) begin
        idle_errs++;
        cur = '0;
      end else begin
        cur = expq.pop_front();
      end
      if (is_b2b) b2b++;
      active = 1'b1;
      bad = 0;
      got = '1;
      got[0] = line;
      if (busy !== 1'b1) bad++;
      if (!is_b2b && done !== 1'b0) bad++;
      cyc = 1;
    endtask

    initial begin
      forever begin
        @(negedge clock);
        if (reset) begin
          active = 1'b0;
        end else if (active && cyc == FL) begin
          total++;
          if (bad != 0 || done !== 1'b1 ||
              got[LEN-1:0] !== cur[LEN-1:0] ||
              busy !== (line === 1'b0)) begin
            fails++;
            $display("FAIL ch%0d frame: got %b expected %b, %0d cycle errors, done %b",
                     g, got[LEN-1:0], cur[LEN-1:0], bad, done);
          end
          active = 1'b0;
          if (line === 1'b0) start_frame(1'b1);
        end else if (active) begin
          if (line !== cur[cyc / CPB]) bad++;
          if (busy !== 1'b1) bad++;
          if (done !== 1'b0) bad++;
          if (cyc % CPB == CPB / 2) got[cyc / CPB] = line;
          cyc++;
        end else begin
          if (line === 1'b0) start_frame(1'b0);
          else if (done !== 1'b0 || busy !== 1'b0) idle_errs++;
        end
      end
    end

    initial begin
      int b0;
      int seen;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_line", g, line, 1);
      chk("rst_busy", g, busy, 0);
      chk("rst_done", g, done, 0);
      chk("rst_count", g, count, 0);
      chk("rst_ready", g, ready, 1);

      push(FIRST);
      chk("e0_line", g, line, 1);
      tick();
      chk("e1_line", g, line, 1);
      chk("e1_count", g, count, 0);
      tick();
      chk("e2_line", g, line, 0);
      chk("e2_busy", g, busy, 1);
      wait_idle();
      push(SECOND);
      wait_idle();

      b0 = b2b;
      for (int i = 0; i < 5; i++) push(9'($urandom));
      chk("burst_ready", g, ready, 0);
      chk("burst_count", g, count, 4);
      push(9'h066);
      chk("drop_count", g, count, 4);
      wait_idle();
      chk("back_to_back", g, b2b - b0, 4);

      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(5) == 0) begin
          push(9'($urandom));
        end else begin
          data = DB'($urandom);
          tick();
        end
      end
      wait_idle();

      for (int i = 0; i < 3; i++) push(9'($urandom));
      for (int i = 0; i < 20 && line !== 1'b0; i++) tick();
      repeat (2 * CPB + 2) tick();
      chk("pre_rst_count", g, count, 2);
      reset = 1'b1;
      expq.delete();
      tick();
      chk("mid_rst_line", g, line, 1);
      chk("mid_rst_count", g, count, 0);
      chk("mid_rst_busy", g, busy, 0);
      reset = 1'b0;
      seen = 0;
      repeat (2 * FL) begin
        tick();
        if (done !== 1'b0 || line !== 1'b1 || busy !== 1'b0) seen++;
      end
      chk("post_rst_quiet", g, seen, 0);

      push(9'($urandom));
      wait_idle();
      chk("idle_errs", g, idle_errs, 0);
      chk("queue_left", g, expq.size(), 0);
      ch_done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(ch_done[0] && ch_done[1]); i++)
      @(posedge clock);
    if (!(ch_done[0] && ch_done[1])) begin
      total++;
      fails++;
      $display("FAIL timeout: channels done %b%b, required 11",
               ch_done[1], ch_done[0]);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
